// File: rtl/ex_stage.sv
// Execute stage: forward muxes, saturating add/sub, xor, shifts, EX/MEM register and Z/V/N flags.
// Optional packed nibble add on opcode 0111 is enabled by defining EX_PADDSB_EN.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [3:0]  id_opcode,
  input  logic [15:0] id_rs_data,
  input  logic [15:0] id_rt_data,
  input  logic [3:0]  id_imm4,
  input  logic [3:0]  id_rd,
  input  logic        id_wr_en,
  input  logic [1:0]  fwd_a_sel,
  input  logic [1:0]  fwd_b_sel,
  input  logic [15:0] mem_fwd_data,
  input  logic [15:0] wb_fwd_data,
  output logic        ex_valid,
  output logic [15:0] ex_result,
  output logic [3:0]  ex_rd,
  output logic        ex_wr_en,
  output logic        ex_illegal,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n
);

  localparam int unsigned DW = 16;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;

  logic [DW-1:0] op_a, op_b;
  logic [DW:0]   wide_sum;
  logic          sat_ovf;
  logic [DW-1:0] sat_res;
  logic [DW-1:0] alu_res;
  logic          supported;
  logic          upd_z, upd_vn;

  // Operand forwarding; select 11 falls back to ID/EX data
  always_comb begin
    unique case (fwd_a_sel)
      2'b01:   op_a = mem_fwd_data;
      2'b10:   op_a = wb_fwd_data;
      default: op_a = id_rs_data;
    endcase
    unique case (fwd_b_sel)
      2'b01:   op_b = mem_fwd_data;
      2'b10:   op_b = wb_fwd_data;
      default: op_b = id_rt_data;
    endcase
  end

  // 17-bit signed sum: top two bits disagree exactly when the 16-bit result overflows
  always_comb begin
    if (id_opcode == OP_SUB) wide_sum = {op_a[DW-1], op_a} - {op_b[DW-1], op_b};
    else                     wide_sum = {op_a[DW-1], op_a} + {op_b[DW-1], op_b};
    sat_ovf = wide_sum[DW] ^ wide_sum[DW-1];
    if (sat_ovf) sat_res = wide_sum[DW] ? 16'h8000 : 16'h7FFF;
    else         sat_res = wide_sum[DW-1:0];
  end

`ifdef EX_PADDSB_EN
  logic [DW-1:0] paddsb_res;
  logic [4:0]    nib_sum;

  always_comb begin
    paddsb_res = '0;
    nib_sum    = '0;
    for (int i = 0; i < 4; i++) begin
      nib_sum = {op_a[4*i+3], op_a[4*i +: 4]} + {op_b[4*i+3], op_b[4*i +: 4]};
      if (nib_sum[4] ^ nib_sum[3]) paddsb_res[4*i +: 4] = nib_sum[4] ? 4'h8 : 4'h7;
      else                         paddsb_res[4*i +: 4] = nib_sum[3:0];
    end
  end
`endif

  always_comb begin
    alu_res   = '0;
    supported = 1'b1;
    upd_z     = 1'b0;
    upd_vn    = 1'b0;
    case (id_opcode)
      OP_ADD, OP_SUB: begin
        alu_res = sat_res;
        upd_z   = 1'b1;
        upd_vn  = 1'b1;
      end
      OP_XOR: begin
        alu_res = op_a ^ op_b;
        upd_z   = 1'b1;
      end
      OP_SLL: begin
        alu_res = op_a << id_imm4;
        upd_z   = 1'b1;
      end
      OP_SRA: begin
        alu_res = DW'($signed(op_a) >>> id_imm4);
        upd_z   = 1'b1;
      end
      OP_ROR: begin
        // Shifting left by 16 yields zero, so imm4=0 passes A through
        alu_res = (op_a >> id_imm4) | (op_a << (5'd16 - 5'(id_imm4)));
        upd_z   = 1'b1;
      end
`ifdef EX_PADDSB_EN
      OP_PADDSB: alu_res = paddsb_res;
`endif
      default: supported = 1'b0;
    endcase
  end

  // EX/MEM register and flags: reset > flush > stall > capture
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_result  <= '0;
      ex_rd      <= '0;
      ex_wr_en   <= 1'b0;
      ex_illegal <= 1'b0;
      flag_z     <= 1'b0;
      flag_v     <= 1'b0;
      flag_n     <= 1'b0;
    end else if (flush || (!stall && !id_valid)) begin
      ex_valid   <= 1'b0;
      ex_result  <= '0;
      ex_rd      <= '0;
      ex_wr_en   <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (!stall) begin
      ex_valid   <= 1'b1;
      ex_result  <= alu_res;
      ex_rd      <= id_rd;
      ex_wr_en   <= id_wr_en & supported;
      ex_illegal <= ~supported;
      if (upd_z) flag_z <= (alu_res == '0);
      if (upd_vn) begin
        flag_v <= sat_ovf;
        flag_n <= sat_res[DW-1];
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: an independent reference model pushes expected EX/MEM state per edge.
module tb_ex_stage;

  typedef struct {
    logic        valid;
    logic [15:0] result;
    logic [3:0]  rd;
    logic        wr_en;
    logic        illegal;
    logic        z, v, n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid, id_wr_en;
  logic [3:0]  id_opcode, id_imm4, id_rd;
  logic [15:0] id_rs_data, id_rt_data, mem_fwd_data, wb_fwd_data;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        ex_valid, ex_wr_en, ex_illegal, flag_z, flag_v, flag_n;
  logic [15:0] ex_result;
  logic [3:0]  ex_rd;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t model;
  exp_t sb[$];

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm4(id_imm4), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
    .ex_illegal(ex_illegal), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] sel_op(input logic [1:0] s, input logic [15:0] d);
    if (s == 2'b01) return mem_fwd_data;
    if (s == 2'b10) return wb_fwd_data;
    return d;
  endfunction

  // Reference model of one clock edge, built from integer arithmetic and bit loops
  task automatic model_edge();
    logic [15:0] a, b, r;
    int ia, ib, s;
    bit legal, uz, uvn, ov;
    if (rst) begin
      model = '{1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      return;
    end
    if (flush || (!stall && !id_valid)) begin
      model.valid = 1'b0; model.result = '0; model.rd = '0;
      model.wr_en = 1'b0; model.illegal = 1'b0;
      return;
    end
    if (stall) return;
    a = sel_op(fwd_a_sel, id_rs_data);
    b = sel_op(fwd_b_sel, id_rt_data);
    r = '0; legal = 1; uz = 0; uvn = 0; ov = 0;
    case (id_opcode)
      4'd0, 4'd1: begin
        ia = $signed(a); ib = $signed(b);
        s = (id_opcode == 4'd0) ? ia + ib : ia - ib;
        if (s > 32767) begin s = 32767; ov = 1; end
        if (s < -32768) begin s = -32768; ov = 1; end
        r = 16'(s); uz = 1; uvn = 1;
      end
      4'd2: begin r = a ^ b; uz = 1; end
      4'd4: begin r = a; for (int k = 0; k < id_imm4; k++) r = {r[14:0], 1'b0}; uz = 1; end
      4'd5: begin r = a; for (int k = 0; k < id_imm4; k++) r = {r[15], r[15:1]}; uz = 1; end
      4'd6: begin r = a; for (int k = 0; k < id_imm4; k++) r = {r[0], r[15:1]}; uz = 1; end
`ifdef EX_PADDSB_EN
      4'd7: begin
        for (int k = 0; k < 4; k++) begin
          logic [3:0] na, nb;
          na = a[4*k +: 4]; nb = b[4*k +: 4];
          ia = $signed(na); ib = $signed(nb); s = ia + ib;
          if (s > 7) s = 7;
          if (s < -8) s = -8;
          r[4*k +: 4] = 4'(s);
        end
      end
`endif
      default: legal = 0;
    endcase
    model.valid = 1'b1; model.result = r; model.rd = id_rd;
    model.wr_en = id_wr_en & legal; model.illegal = !legal;
    if (uz) model.z = (r == 16'h0);
    if (uvn) begin model.v = ov; model.n = r[15]; end
  endtask

  // Push the expectation for the coming edge, clock, then pop and compare
  task automatic step();
    exp_t e;
    model_edge();
    sb.push_back(model);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("valid", 16'(ex_valid), 16'(e.valid));
    check("result", ex_result, e.result);
    check("rd", 16'(ex_rd), 16'(e.rd));
    check("wr_en", 16'(ex_wr_en), 16'(e.wr_en));
    check("illegal", 16'(ex_illegal), 16'(e.illegal));
    check("flag_z", 16'(flag_z), 16'(e.z));
    check("flag_v", 16'(flag_v), 16'(e.v));
    check("flag_n", 16'(flag_n), 16'(e.n));
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] imm, input logic [3:0] rd);
    id_valid = 1'b1; id_wr_en = 1'b1; id_opcode = op;
    id_rs_data = a; id_rt_data = b; id_imm4 = imm; id_rd = rd;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model = '{1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    rst = 1; stall = 0; flush = 0; id_valid = 0; id_wr_en = 0;
    id_opcode = '0; id_imm4 = '0; id_rd = '0; id_rs_data = '0; id_rt_data = '0;
    fwd_a_sel = '0; fwd_b_sel = '0; mem_fwd_data = '0; wb_fwd_data = '0;
    step();
    check("reset_result", ex_result, 16'h0000);
    check("reset_valid", 16'(ex_valid), 16'h0);
    rst = 0;

    issue(4'd0, 16'h7000, 16'h2000, 4'd0, 4'd1);
    check("add_pos_sat", ex_result, 16'h7FFF);
    check("add_pos_sat_v", 16'(flag_v), 16'h1);
    issue(4'd1, 16'h1234, 16'h1234, 4'd0, 4'd2);
    check("sub_zero_z", 16'(flag_z), 16'h1);
    issue(4'd2, 16'h00FF, 16'h00FF, 4'd0, 4'd3);
    issue(4'd0, 16'h8000, 16'hFFFF, 4'd0, 4'd4);
    check("add_neg_sat", ex_result, 16'h8000);
    issue(4'd5, 16'h8010, 16'h0000, 4'd4, 4'd5);
    check("sra", ex_result, 16'hF801);
    issue(4'd6, 16'h0001, 16'h0000, 4'd1, 4'd6);
    check("ror", ex_result, 16'h8000);
    issue(4'd6, 16'hA5C3, 16'h0000, 4'd0, 4'd6);
    check("ror_zero", ex_result, 16'hA5C3);
    issue(4'd4, 16'h0001, 16'h0000, 4'd15, 4'd7);
    check("sll", ex_result, 16'h8000);
    issue(4'd1, 16'h0000, 16'h8000, 4'd0, 4'd8);
    check("sub_pos_sat", ex_result, 16'h7FFF);

    fwd_a_sel = 2'b01; mem_fwd_data = 16'h0100;
    fwd_b_sel = 2'b10; wb_fwd_data = 16'h0002;
    issue(4'd0, 16'h0001, 16'h0001, 4'd0, 4'd9);
    check("fwd_add", ex_result, 16'h0102);
    fwd_a_sel = 2'b11; fwd_b_sel = 2'b11;
    issue(4'd1, 16'h0005, 16'h0007, 4'd0, 4'd9);
    fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;

    stall = 1;
    for (int i = 0; i < 3; i++) issue(4'd0, 16'h0010, 16'h0020, 4'd0, 4'd10);
    check("stall_hold", ex_result, 16'hFFFE);
    flush = 1;
    issue(4'd0, 16'h0000, 16'h0000, 4'd0, 4'd11);
    check("stall_flush_valid", 16'(ex_valid), 16'h0);
    stall = 0; flush = 0;

    issue(4'd3, 16'h1234, 16'h4321, 4'd0, 4'd12);
    check("red_illegal", 16'(ex_illegal), 16'h1);
    issue(4'd7, 16'h7321, 16'h1717, 4'd0, 4'd13);
`ifdef EX_PADDSB_EN
    check("paddsb", ex_result, 16'h7737);
`else
    check("paddsb_off", ex_result, 16'h0000);
`endif
    id_valid = 0;
    step();

    for (int i = 0; i < 300; i++) begin
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 11) == 0);
      id_valid = ($urandom_range(0, 5) != 0);
      id_wr_en = $urandom_range(0, 1);
      id_opcode = 4'($urandom_range(0, 8));
      id_imm4 = 4'($urandom);
      id_rd = 4'($urandom);
      id_rs_data = ($urandom_range(0, 4) == 0) ? 16'h8000 : 16'($urandom);
      id_rt_data = ($urandom_range(0, 4) == 0) ? id_rs_data : 16'($urandom);
      fwd_a_sel = 2'($urandom); fwd_b_sel = 2'($urandom);
      mem_fwd_data = 16'($urandom); wb_fwd_data = 16'($urandom);
      step();
    end

    stall = 1; flush = 1; rst = 1;
    step();
    check("rst_over_stall_flush", ex_result, 16'h0000);
    rst = 0; stall = 0; flush = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
